cache_mem_bridge: RTL and testbench

- Sits directly downstream of the cache controller, on its mem_read / mem_write / mem_address / mem_write_data / mem_read_data port.
- Decouples cache write-backs and flush traffic from a slower external memory port. It does this with a posted write buffer (FIFO), read-after-write forwarding from that buffer, and a req/ack handshake toward external memory.
- Read fills bypass queued writes to other addresses.

---
 rtl/cache_mem_pkg.sv | 19 +
 rtl/cache_wbuf_fifo.sv | 91 +++++++++
 rtl/cache_mem_bridge.sv | 167 ++++++++++++++++
 tb/tb_cache_mem_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and default sizing for the cache-to-memory bridge and its write buffer.
package cache_mem_pkg;

    localparam int unsigned WBUF_DEPTH = 4;
    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } wbuf_entry_t;

endpackage

// File: rtl/cache_wbuf_fifo.sv
// Posted write buffer: circular FIFO of {addr, data} with a youngest-match lookup port.
module cache_wbuf_fifo
    import cache_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr_c,
    output logic [DATA_W-1:0] head_data_c,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit_c,
    output logic [DATA_W-1:0] hit_data_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              do_push;
    logic              do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally; full/empty are registered from the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_addr_c = addr_mem[rd_ptr];
    assign head_data_c = data_mem[rd_ptr];

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (addr_mem[rd_ptr + PTR_W'(i)] == lookup_addr)) begin
                hit_c      = 1'b1;
                hit_data_c = data_mem[rd_ptr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/cache_mem_bridge.sv
// Cache-side memory bridge: posted write buffer, read forwarding from the buffer,
// and a req/ack sequencer toward the slower external memory port.
module cache_mem_bridge
    import cache_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = WBUF_DEPTH,
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_write_data,
    output logic [DATA_W-1:0] mem_read_data,
    output logic              mem_rvalid,
    output logic              wbuf_full,
    output logic              wbuf_empty,
    output logic              err_overflow,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_WR   = 2'(WR_REQ);
    localparam logic [1:0] S_RD   = 2'(RD_REQ);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              mem_read_q;
    logic              rd_pending;
    logic [ADDR_W-1:0] rd_addr;

    logic              push_c;
    logic              pop_c;
    logic              rd_start_c;
    logic              rd_miss_c;
    logic              fwd_hit_c;
    logic              buf_hit_c;
    logic [DATA_W-1:0] fwd_data_c;
    logic [DATA_W-1:0] buf_data_c;
    logic [ADDR_W-1:0] head_addr_c;
    logic [DATA_W-1:0] head_data_c;
    logic [ADDR_W-1:0] rd_target_c;

    cache_wbuf_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push        (mem_write),
        .push_addr   (mem_address),
        .push_data   (mem_write_data),
        .pop         (pop_c),
        .head_addr_c (head_addr_c),
        .head_data_c (head_data_c),
        .full        (wbuf_full),
        .empty       (wbuf_empty),
        .lookup_addr (mem_address),
        .hit_c       (buf_hit_c),
        .hit_data_c  (buf_data_c)
    );

    // A same-cycle push shares mem_address with the lookup, so it always hits and is youngest.
    assign push_c      = mem_write & ~wbuf_full;
    assign pop_c       = (state == S_WR) & ext_ack;
    assign rd_start_c  = mem_read & ~mem_read_q & ~rd_pending;
    assign fwd_hit_c   = push_c | buf_hit_c;
    assign fwd_data_c  = push_c ? mem_write_data : buf_data_c;
    assign rd_miss_c   = rd_start_c & ~fwd_hit_c;
    assign rd_target_c = rd_pending ? rd_addr : mem_address;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reads (pending or missing this cycle) take priority over draining the buffer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (rd_pending || rd_miss_c) begin
                    state_nxt = S_RD;
                end else if (!wbuf_empty) begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (ext_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                if (ext_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_q    <= 1'b0;
            rd_pending    <= 1'b0;
            rd_addr       <= '0;
            mem_read_data <= '0;
            mem_rvalid    <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            mem_read_q <= mem_read;
            mem_rvalid <= 1'b0;
            if (mem_write && wbuf_full) begin
                err_overflow <= 1'b1;
            end
            if (rd_start_c) begin
                rd_addr <= mem_address;
                if (fwd_hit_c) begin
                    mem_read_data <= fwd_data_c;
                    mem_rvalid    <= 1'b1;
                end else begin
                    rd_pending <= 1'b1;
                end
            end
            if ((state == S_RD) && ext_ack) begin
                mem_read_data <= ext_rdata;
                mem_rvalid    <= 1'b1;
                rd_pending    <= 1'b0;
            end
        end
    end

    // External bus fields load on leaving IDLE and hold until the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
        end else begin
            ext_req <= (state_nxt != S_IDLE);
            if (state == S_IDLE) begin
                if (state_nxt == S_RD) begin
                    ext_we    <= 1'b0;
                    ext_addr  <= rd_target_c;
                    ext_wdata <= '0;
                end else if (state_nxt == S_WR) begin
                    ext_we    <= 1'b1;
                    ext_addr  <= head_addr_c;
                    ext_wdata <= head_data_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Bench for cache_mem_bridge: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cache_mem_bridge;
    import cache_mem_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [DW-1:0] mem_write_data = '0;
    logic [DW-1:0] mem_read_data;
    logic          mem_rvalid;
    logic          wbuf_full;
    logic          wbuf_empty;
    logic          err_overflow;
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_ack = 1'b0;
    logic [DW-1:0] ext_rdata = '0;

    cache_mem_bridge #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_rvalid     (mem_rvalid),
        .wbuf_full      (wbuf_full),
        .wbuf_empty     (wbuf_empty),
        .err_overflow   (err_overflow),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_ack        (ext_ack),
        .ext_rdata      (ext_rdata)
    );

    always #5 clk = ~clk;

    // External memory responder: ack after ack_lat request cycles.
    int unsigned   ack_lat = 1;
    logic          ack_en = 1'b1;
    logic          stale_ack = 1'b0;
    logic [DW-1:0] rdata_val = '0;
    logic          resp_ack = 1'b0;
    int unsigned   wcnt = 0;

    always begin
        @(posedge clk);
        #2;
        if (reset || resp_ack) begin
            resp_ack = 1'b0;
            wcnt     = 0;
        end else if (ext_req && ack_en) begin
            wcnt++;
            if (wcnt >= ack_lat) resp_ack = 1'b1;
        end
        ext_ack   = resp_ack | stale_ack;
        ext_rdata = resp_ack ? rdata_val : '0;
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_ext_rd = 0;
    int n_ext_wr = 0;
    logic [AW-1:0] last_wr_addr = '0;

    // Reference model state
    wbuf_entry_t   mq[$];
    wbuf_entry_t   ent;
    logic          m_ovf, m_pend, pend_old, prev_rd;
    logic [AW-1:0] m_raddr;
    logic          exp_rv, nxt_rv, full_now, hit;
    logic [DW-1:0] exp_rd, nxt_rd, hdata;
    logic          p_req, p_hs, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_to(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!ext_req && n < 50) begin step(); n++; end
        if (!ext_req) fail_to(name);
    endtask

    task automatic wait_rvalid(input string name);
        int n = 0;
        while (!mem_rvalid && n < 50) begin step(); n++; end
        if (!mem_rvalid) fail_to(name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(wbuf_empty && !ext_req) && n < 200) begin step(); n++; end
        if (!(wbuf_empty && !ext_req)) fail_to(name);
    endtask

    task automatic wait_notfull(input string name);
        int n = 0;
        while (wbuf_full && n < 50) begin step(); n++; end
        if (wbuf_full) fail_to(name);
    endtask

    initial begin
        int rd0;
        int wr0;
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    chk("rst_ext_req", 64'(ext_req), 64'(0));
                    chk("rst_rvalid", 64'(mem_rvalid), 64'(0));
                    chk("rst_rdata", 64'(mem_read_data), 64'(0));
                    chk("rst_ovf", 64'(err_overflow), 64'(0));
                    chk("rst_empty", 64'(wbuf_empty), 64'(1));
                    chk("rst_full", 64'(wbuf_full), 64'(0));
                    mq.delete();
                    m_ovf = 0; m_pend = 0; prev_rd = 0; m_raddr = '0;
                    exp_rv = 0; exp_rd = '0; p_req = 0; p_hs = 0; p_we = 0;
                    p_addr = '0; p_wdata = '0;
                    continue;
                end
                chk("wbuf_empty", 64'(wbuf_empty), 64'(mq.size() == 0));
                chk("wbuf_full", 64'(wbuf_full), 64'(mq.size() == DEPTH));
                chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
                chk("mem_rvalid", 64'(mem_rvalid), 64'(exp_rv));
                if (exp_rv) chk("mem_read_data", 64'(mem_read_data), 64'(exp_rd));
                if (p_hs) begin
                    chk("ext_req_gap", 64'(ext_req), 64'(0));
                end else if (p_req) begin
                    chk("ext_req_held", 64'(ext_req), 64'(1));
                    chk("ext_we_stable", 64'(ext_we), 64'(p_we));
                    chk("ext_addr_stable", 64'(ext_addr), 64'(p_addr));
                    if (p_we) chk("ext_wdata_stable", 64'(ext_wdata), 64'(p_wdata));
                end
                // Predict the coming posedge from the inputs now applied.
                nxt_rv = 0;
                nxt_rd = exp_rd;
                pend_old = m_pend;
                full_now = (mq.size() == DEPTH);
                if (mem_read && !prev_rd && !pend_old) begin
                    hit = 0;
                    hdata = '0;
                    foreach (mq[i]) if (mq[i].addr == mem_address) begin hit = 1; hdata = mq[i].data; end
                    if (mem_write && !full_now) begin hit = 1; hdata = mem_write_data; end
                    if (hit) begin nxt_rv = 1; nxt_rd = hdata; end
                    else begin m_pend = 1; m_raddr = mem_address; end
                end
                if (ext_req && ext_ack) begin
                    if (ext_we) begin
                        n_ext_wr++;
                        last_wr_addr = ext_addr;
                        if (mq.size() == 0) fail_to("ext_wr_unexpected");
                        else begin
                            chk("ext_wr_addr", 64'(ext_addr), 64'(mq[0].addr));
                            chk("ext_wr_data", 64'(ext_wdata), 64'(mq[0].data));
                            void'(mq.pop_front());
                        end
                    end else begin
                        n_ext_rd++;
                        chk("ext_rd_pending", 64'(pend_old), 64'(1));
                        chk("ext_rd_addr", 64'(ext_addr), 64'(m_raddr));
                        nxt_rv = 1;
                        nxt_rd = ext_rdata;
                        m_pend = 0;
                    end
                end
                if (mem_write) begin
                    if (full_now) m_ovf = 1;
                    else begin
                        ent.addr = mem_address;
                        ent.data = mem_write_data;
                        mq.push_back(ent);
                    end
                end
                prev_rd = mem_read;
                exp_rv  = nxt_rv;
                exp_rd  = nxt_rd;
                p_req   = ext_req;
                p_hs    = ext_req & ext_ack;
                p_we    = ext_we;
                p_addr  = ext_addr;
                p_wdata = ext_wdata;
            end
        join_none

        // Power-on reset
        #1 reset = 1'b1;
        #1;
        chk("por_ext_req", 64'(ext_req), 64'(0));
        chk("por_empty", 64'(wbuf_empty), 64'(1));
        chk("por_ovf", 64'(err_overflow), 64'(0));
        step();
        step();
        reset = 1'b0;
        step();

        // Read miss takes priority over a queued write
        ack_en = 1; ack_lat = 3; rdata_val = 32'h1234_5678;
        mem_write = 1; mem_address = 32'h100; mem_write_data = 32'hAAAA_0001;
        step();
        mem_write = 0; mem_read = 1; mem_address = 32'h200;
        step();
        mem_read = 0;
        wait_req("rd_first_req");
        chk("rd_first_we", 64'(ext_we), 64'(0));
        chk("rd_first_addr", 64'(ext_addr), 64'(32'h200));
        wait_rvalid("rd_first_rvalid");
        chk("rd_first_data", 64'(mem_read_data), 64'(32'h1234_5678));
        wait_req("wr_after_rd_req");
        chk("wr_after_rd_we", 64'(ext_we), 64'(1));
        chk("wr_after_rd_addr", 64'(ext_addr), 64'(32'h100));
        chk("wr_after_rd_data", 64'(ext_wdata), 64'(32'hAAAA_0001));
        wait_idle("t2_idle");

        // Forward youngest of two matching buffered writes
        ack_en = 0; ack_lat = 1;
        mem_write = 1; mem_address = 32'h40; mem_write_data = 32'h11;
        step();
        mem_write_data = 32'h22;
        step();
        mem_write = 0;
        wait_req("fwd_head_req");
        chk("fwd_head_addr", 64'(ext_addr), 64'(32'h40));
        chk("fwd_head_data", 64'(ext_wdata), 64'(32'h11));
        rd0 = n_ext_rd;
        mem_read = 1; mem_address = 32'h40;
        step();
        mem_read = 0;
        chk("fwd_rvalid", 64'(mem_rvalid), 64'(1));
        chk("fwd_data", 64'(mem_read_data), 64'(32'h22));
        ack_en = 1;
        wait_idle("t3_idle");
        chk("fwd_no_ext_rd", 64'(n_ext_rd), 64'(rd0));

        // Overflow with acks held off
        ack_en = 0;
        wr0 = n_ext_wr;
        for (int i = 0; i < 5; i++) begin
            mem_write = 1; mem_address = 32'h300 + 32'(i); mem_write_data = 32'hD0 + 32'(i);
            step();
            if (i == 3) begin
                chk("ovf_full4", 64'(wbuf_full), 64'(1));
                chk("ovf_not_yet", 64'(err_overflow), 64'(0));
            end
            if (i == 4) chk("ovf_sticky", 64'(err_overflow), 64'(1));
        end
        mem_write = 0;
        ack_en = 1;
        wait_idle("t4_idle");
        chk("ovf_drain_cnt", 64'(n_ext_wr - wr0), 64'(4));
        chk("ovf_last_addr", 64'(last_wr_addr), 64'(32'h303));

        // Same-cycle write and read forward
        rd0 = n_ext_rd;
        mem_write = 1; mem_read = 1; mem_address = 32'h80; mem_write_data = 32'h5A;
        step();
        mem_write = 0; mem_read = 0;
        chk("same_rvalid", 64'(mem_rvalid), 64'(1));
        chk("same_data", 64'(mem_read_data), 64'(32'h5A));
        wait_idle("t5_idle");
        chk("same_no_ext_rd", 64'(n_ext_rd), 64'(rd0));

        // Ten flush writes, pointers wrap
        wr0 = n_ext_wr;
        for (int i = 0; i < 10; i++) begin
            wait_notfull("flush_notfull");
            mem_write = 1; mem_address = 32'h600 + 32'(i); mem_write_data = 32'hF000 + 32'(i);
            step();
            mem_write = 0;
            step();
        end
        wait_idle("t6_idle");
        chk("flush_cnt", 64'(n_ext_wr - wr0), 64'(10));
        chk("flush_last", 64'(last_wr_addr), 64'(32'h609));
        chk("flush_empty", 64'(wbuf_empty), 64'(1));

        // Asynchronous reset during WR_REQ, then a stale ack
        ack_en = 0;
        mem_write = 1; mem_address = 32'h500; mem_write_data = 32'h77;
        step();
        mem_write = 0;
        wait_req("rst_wr_req");
        #2 reset = 1'b1;
        #1;
        chk("arst_ext_req", 64'(ext_req), 64'(0));
        chk("arst_empty", 64'(wbuf_empty), 64'(1));
        chk("arst_rvalid", 64'(mem_rvalid), 64'(0));
        chk("arst_ovf", 64'(err_overflow), 64'(0));
        step();
        step();
        reset = 1'b0;
        wr0 = n_ext_wr;
        stale_ack = 1;
        step();
        stale_ack = 0;
        step();
        step();
        chk("stale_ext_req", 64'(ext_req), 64'(0));
        chk("stale_empty", 64'(wbuf_empty), 64'(1));
        chk("stale_no_wr", 64'(n_ext_wr), 64'(wr0));
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
